// File: rtl/lock_pkg.sv
// Shared definitions for the combination lock: FSM states, the relock key and
// the status-display patterns.
package lock_pkg;

    typedef enum logic [1:0] {
        ST_ENTRY    = 2'd0,
        ST_UNLOCKED = 2'd1,
        ST_PROGRAM  = 2'd2,
        ST_LOCKOUT  = 2'd3
    } lock_state_t;

    // Relock digit is all-ones at whatever digit width the lock is built with.
    localparam logic [31:0] RELOCK_KEY    = 32'hFFFF_FFFF;

    localparam logic [7:0]  LED_OFF       = 8'h00;
    localparam logic [7:0]  LED_UNLOCKED  = 8'hFF;
    localparam logic [7:0]  LED_LOCKOUT   = 8'hAA;
    localparam logic [7:0]  LED_PROG_FLAG = 8'h80;

    function automatic logic [6:0] thermo(input int n);
        logic [6:0] t;
        for (int i = 0; i < 7; i++) t[i] = (i < n);
        return t;
    endfunction

endpackage

// File: rtl/lock_timer.sv
// Lockout down-counter: loads a fixed cycle count, decrements to zero and
// reports when it is at zero or about to reach it.
module lock_timer #(
    parameter int unsigned CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic dec,
    output logic zero,
    output logic last
);

    localparam int W = (CYCLES < 1) ? 1 : $clog2(CYCLES + 1);

    logic [W-1:0] count;

    // NOTE: sequential state is written with <= so every flop samples the
    // values from before the edge, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= W'(CYCLES);
        end else if (dec && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);
    assign last = (count == W'(1));

endmodule

// File: rtl/param_combination_lock.sv
// Parameterised keypad combination lock with sticky-error code entry,
// fail counting with timed lockout, and atomic in-field reprogramming.
module param_combination_lock
    import lock_pkg::*;
#(
    parameter int unsigned CODE_LEN    = 5,
    parameter int unsigned DIGIT_W     = 4,
    parameter int unsigned MAX_FAIL    = 3,
    parameter int unsigned LOCKOUT_CYC = 16,
    parameter logic [CODE_LEN*DIGIT_W-1:0] DEFAULT_CODE = 20'h02814
) (
    input  logic               Lock_CLK,
    input  logic               Lock_RST,
    input  logic [DIGIT_W-1:0] Key_IN,
    input  logic               Key_VALID,
    input  logic               Prog_EN,
    output logic [7:0]         LED_graph,
    output logic               Unlocked,
    output logic               Alarm
);

    localparam int CODE_W = CODE_LEN * DIGIT_W;
    localparam int IDX_W  = $clog2(CODE_LEN + 1);
    localparam int FAIL_W = $clog2(MAX_FAIL + 1);
    localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(CODE_LEN - 1);
    localparam logic [FAIL_W-1:0] FAIL_LIMIT = FAIL_W'(MAX_FAIL);

    lock_state_t        state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   pcnt_q, pcnt_d;
    logic               err_q, err_d;
    logic [FAIL_W-1:0]  fail_q, fail_d;
    logic [CODE_W-1:0]  code_q, code_d;
    logic [CODE_W-1:0]  shadow_q, shadow_d;
    logic               key_block_q;
    logic [7:0]         led_d;

    logic               key_ok;
    logic [DIGIT_W-1:0] exp_digit;
    logic               mismatch;
    logic               tmr_load, tmr_dec, tmr_zero, tmr_last;

    lock_timer #(.CYCLES(LOCKOUT_CYC)) u_timer (
        .clk  (Lock_CLK),
        .rst  (Lock_RST),
        .load (tmr_load),
        .dec  (tmr_dec),
        .zero (tmr_zero),
        .last (tmr_last)
    );

    // A strobe on the first edge after reset release is dropped.
    assign key_ok    = Key_VALID && !key_block_q;
    assign exp_digit = code_q[DIGIT_W*(CODE_LEN-1-int'(idx_q)) +: DIGIT_W];
    assign mismatch  = (Key_IN != exp_digit);

    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        err_d    = err_q;
        fail_d   = fail_q;
        code_d   = code_q;
        shadow_d = shadow_q;
        pcnt_d   = pcnt_q;
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;

        unique case (state_q)
            ST_ENTRY: begin
                if (key_ok) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d = '0;
                        err_d = 1'b0;
                        if (!(err_q || mismatch)) begin
                            state_d = ST_UNLOCKED;
                            fail_d  = '0;
                        end else if ({1'b0, fail_q} + 1'b1 >= {1'b0, FAIL_LIMIT}) begin
                            state_d  = ST_LOCKOUT;
                            fail_d   = FAIL_LIMIT;
                            tmr_load = 1'b1;
                        end else begin
                            fail_d = fail_q + 1'b1;
                        end
                    end else begin
                        idx_d = idx_q + 1'b1;
                        err_d = err_q || mismatch;
                    end
                end
            end

            ST_UNLOCKED: begin
                if (key_ok) begin
                    if (Prog_EN) begin
                        state_d  = ST_PROGRAM;
                        pcnt_d   = '0;
                        shadow_d = '0;
                    end else if (Key_IN == RELOCK_KEY[DIGIT_W-1:0]) begin
                        state_d = ST_ENTRY;
                        idx_d   = '0;
                        err_d   = 1'b0;
                    end
                end
            end

            ST_PROGRAM: begin
                if (!Prog_EN) begin
                    state_d  = ST_UNLOCKED;
                    shadow_d = '0;
                    pcnt_d   = '0;
                end else if (key_ok) begin
                    shadow_d[DIGIT_W*(CODE_LEN-1-int'(pcnt_q)) +: DIGIT_W] = Key_IN;
                    if (pcnt_q == LAST_IDX) begin
                        code_d  = shadow_d;
                        pcnt_d  = '0;
                        state_d = ST_ENTRY;
                        idx_d   = '0;
                        err_d   = 1'b0;
                    end else begin
                        pcnt_d = pcnt_q + 1'b1;
                    end
                end
            end

            ST_LOCKOUT: begin
                tmr_dec = 1'b1;
                if (tmr_last || tmr_zero) begin
                    state_d = ST_ENTRY;
                    fail_d  = '0;
                    idx_d   = '0;
                    err_d   = 1'b0;
                end
            end
        endcase
    end

    // Display is derived from the next state so it lands with the state change.
    always_comb begin
        led_d = LED_OFF;
        unique case (state_d)
            ST_ENTRY:    led_d = {1'b0, thermo(int'(idx_d))};
            ST_UNLOCKED: led_d = LED_UNLOCKED;
            ST_PROGRAM:  led_d = LED_PROG_FLAG | {1'b0, thermo(int'(pcnt_d))};
            ST_LOCKOUT:  led_d = LED_LOCKOUT;
        endcase
    end

    // NOTE: the stored code is a small register, not a RAM, so it is reset
    // like any other flop to restore the factory code.
    always_ff @(posedge Lock_CLK or posedge Lock_RST) begin
        if (Lock_RST) begin
            state_q     <= ST_ENTRY;
            idx_q       <= '0;
            err_q       <= 1'b0;
            fail_q      <= '0;
            code_q      <= DEFAULT_CODE;
            shadow_q    <= '0;
            pcnt_q      <= '0;
            key_block_q <= 1'b1;
            LED_graph   <= LED_OFF;
            Unlocked    <= 1'b0;
            Alarm       <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            err_q       <= err_d;
            fail_q      <= fail_d;
            code_q      <= code_d;
            shadow_q    <= shadow_d;
            pcnt_q      <= pcnt_d;
            key_block_q <= 1'b0;
            LED_graph   <= led_d;
            Unlocked    <= (state_d == ST_UNLOCKED);
            Alarm       <= (state_d == ST_LOCKOUT);
        end
    end

endmodule

// File: tb/tb_param_combination_lock.sv
// Scoreboard bench for param_combination_lock: a behavioural model predicts
// the display and flags for every cycle; a monitor compares them.
module tb_param_combination_lock;

    localparam int CODE_LEN    = 5;
    localparam int MAX_FAIL    = 3;
    localparam int LOCKOUT_CYC = 16;

    localparam int M_ENTRY    = 0;
    localparam int M_UNLOCKED = 1;
    localparam int M_PROGRAM  = 2;
    localparam int M_LOCKOUT  = 3;

    typedef int code_t [CODE_LEN];
    typedef struct {
        logic [7:0] led;
        logic       unl;
        logic       alm;
    } exp_t;

    logic       Lock_CLK  = 1'b0;
    logic       Lock_RST  = 1'b1;
    logic [3:0] Key_IN    = 4'd0;
    logic       Key_VALID = 1'b0;
    logic       Prog_EN   = 1'b0;
    logic [7:0] LED_graph;
    logic       Unlocked;
    logic       Alarm;

    param_combination_lock dut (
        .Lock_CLK  (Lock_CLK),
        .Lock_RST  (Lock_RST),
        .Key_IN    (Key_IN),
        .Key_VALID (Key_VALID),
        .Prog_EN   (Prog_EN),
        .LED_graph (LED_graph),
        .Unlocked  (Unlocked),
        .Alarm     (Alarm)
    );

    always #5 Lock_CLK = ~Lock_CLK;

    // Reference model state
    int    m_mode;
    int    m_entered[$];
    int    m_prog[$];
    code_t m_code;
    int    m_fails;
    int    m_left;
    bit    m_block;
    code_t def_code = '{0, 2, 8, 1, 4};

    exp_t  sb[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    cyc      = 0;

    task automatic model_reset();
        m_mode = M_ENTRY;
        m_entered.delete();
        m_prog.delete();
        m_code  = def_code;
        m_fails = 0;
        m_left  = 0;
        m_block = 1'b1;
    endtask

    task automatic model_step(input bit v, input int k, input bit p);
        bit ok;
        if (m_block) begin
            m_block = 1'b0;
            v = 1'b0;
        end
        case (m_mode)
            M_ENTRY: if (v) begin
                m_entered.push_back(k);
                if (m_entered.size() == CODE_LEN) begin
                    ok = 1'b1;
                    for (int i = 0; i < CODE_LEN; i++)
                        if (m_entered[i] != m_code[i]) ok = 1'b0;
                    m_entered.delete();
                    if (ok) begin
                        m_mode  = M_UNLOCKED;
                        m_fails = 0;
                    end else begin
                        m_fails++;
                        if (m_fails >= MAX_FAIL) begin
                            m_mode = M_LOCKOUT;
                            m_left = LOCKOUT_CYC;
                        end
                    end
                end
            end
            M_UNLOCKED: if (v) begin
                if (p) begin
                    m_mode = M_PROGRAM;
                    m_prog.delete();
                end else if (k == 15) begin
                    m_mode = M_ENTRY;
                end
            end
            M_PROGRAM: begin
                if (!p) begin
                    m_mode = M_UNLOCKED;
                    m_prog.delete();
                end else if (v) begin
                    m_prog.push_back(k);
                    if (m_prog.size() == CODE_LEN) begin
                        for (int i = 0; i < CODE_LEN; i++) m_code[i] = m_prog[i];
                        m_prog.delete();
                        m_mode = M_ENTRY;
                    end
                end
            end
            default: begin
                m_left--;
                if (m_left <= 0) begin
                    m_mode  = M_ENTRY;
                    m_fails = 0;
                end
            end
        endcase
    endtask

    function automatic exp_t model_outputs();
        exp_t e;
        e.led = 8'h00;
        e.unl = 1'b0;
        e.alm = 1'b0;
        case (m_mode)
            M_ENTRY:    e.led = 8'((1 << m_entered.size()) - 1);
            M_UNLOCKED: begin e.led = 8'hFF; e.unl = 1'b1; end
            M_PROGRAM:  e.led = 8'h80 | 8'((1 << m_prog.size()) - 1);
            default:    begin e.led = 8'hAA; e.alm = 1'b1; end
        endcase
        return e;
    endfunction

    task automatic tick(input bit v, input int k, input bit p);
        Key_VALID = v;
        Key_IN    = 4'(k);
        Prog_EN   = p;
        model_step(v, k, p);
        sb.push_back(model_outputs());
        @(posedge Lock_CLK);
        #1;
    endtask

    task automatic idle(input int n, input bit p);
        for (int i = 0; i < n; i++) tick(1'b0, int'($urandom_range(0, 15)), p);
    endtask

    task automatic send_code(input code_t c, input bit p);
        for (int i = 0; i < CODE_LEN; i++) begin
            idle(int'($urandom_range(0, 2)), p);
            tick(1'b1, c[i], p);
        end
    endtask

    task automatic make_wrong(output code_t c);
        for (int i = 0; i < CODE_LEN; i++) c[i] = int'($urandom_range(0, 15));
        if (c == m_code) c[CODE_LEN-1] = (m_code[CODE_LEN-1] + 1) % 16;
    endtask

    // Short pulse between edges: only an asynchronous reset can act on it.
    task automatic pulse_reset();
        @(negedge Lock_CLK);
        #2;
        Lock_RST  = 1'b1;
        Key_VALID = 1'b1;
        Key_IN    = 4'(m_code[0]);
        #2;
        Lock_RST = 1'b0;
        model_reset();
        tick(1'b1, 0, 1'b0);
    endtask

    always @(negedge Lock_CLK) begin
        exp_t e;
        cyc++;
        if (Lock_RST) begin
            n_checks++;
            if (LED_graph !== 8'h00 || Unlocked !== 1'b0 || Alarm !== 1'b0) begin
                n_fail++;
                $display("FAIL in_reset cyc%0d: got led=%h unl=%b alm=%b, want 00/0/0",
                         cyc, LED_graph, Unlocked, Alarm);
            end
        end else if (sb.size() > 0) begin
            e = sb.pop_front();
            n_checks++;
            if (LED_graph !== e.led || Unlocked !== e.unl || Alarm !== e.alm) begin
                n_fail++;
                $display("FAIL scoreboard cyc%0d: got led=%h unl=%b alm=%b, want led=%h unl=%b alm=%b",
                         cyc, LED_graph, Unlocked, Alarm, e.led, e.unl, e.alm);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        code_t bad;
        code_t new_code = '{7, 7, 3, 3, 1};

        model_reset();
        repeat (3) @(posedge Lock_CLK);
        @(negedge Lock_CLK);
        #2;
        Lock_RST = 1'b0;
        tick(1'b1, 0, 1'b0);

        // Key_IN toggling without a strobe, then the factory code
        idle(6, 1'b0);
        send_code(def_code, 1'b0);
        idle(2, 1'b0);
        tick(1'b1, 15, 1'b0);

        // One wrong code, then the right one
        bad = def_code;
        bad[4] = 5;
        send_code(bad, 1'b0);
        idle(2, 1'b0);
        send_code(def_code, 1'b0);
        tick(1'b1, 15, 1'b0);

        // Lockout with keys hammered throughout, then recovery
        repeat (MAX_FAIL) begin
            make_wrong(bad);
            send_code(bad, 1'b0);
        end
        repeat (LOCKOUT_CYC) tick(1'b1, int'($urandom_range(0, 15)), 1'b0);
        idle(2, 1'b0);
        send_code(def_code, 1'b0);

        // Reprogram, old code fails, new code unlocks
        tick(1'b1, int'($urandom_range(0, 15)), 1'b1);
        send_code(new_code, 1'b1);
        idle(1, 1'b0);
        send_code(def_code, 1'b0);
        send_code(new_code, 1'b0);

        // Abandoned programming keeps the current code
        tick(1'b1, 4, 1'b1);
        tick(1'b1, 9, 1'b1);
        tick(1'b1, 9, 1'b1);
        tick(1'b0, 0, 1'b0);
        tick(1'b1, 15, 1'b0);
        send_code(new_code, 1'b0);
        tick(1'b1, 15, 1'b0);

        // Reset mid-entry
        tick(1'b1, 7, 1'b0);
        tick(1'b1, 7, 1'b0);
        pulse_reset();
        idle(2, 1'b0);
        send_code(def_code, 1'b0);

        // Reset mid-program
        tick(1'b1, 2, 1'b1);
        repeat (3) tick(1'b1, 1, 1'b1);
        pulse_reset();
        send_code(def_code, 1'b0);
        tick(1'b1, 15, 1'b0);

        // Reset mid-lockout
        repeat (MAX_FAIL) begin
            make_wrong(bad);
            send_code(bad, 1'b0);
        end
        idle(5, 1'b0);
        pulse_reset();
        send_code(def_code, 1'b0);
        tick(1'b1, 15, 1'b0);

        // Random traffic
        repeat (400) begin
            if ($urandom_range(0, 5) == 0) begin
                send_code(m_code, 1'b0);
            end else begin
                tick($urandom_range(0, 2) == 0,
                     ($urandom_range(0, 4) == 0) ? 15 : int'($urandom_range(0, 15)),
                     1'($urandom_range(0, 1)));
            end
        end

        idle(2, 1'b0);
        @(negedge Lock_CLK);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
